// File: rtl/sdram_arbiter.sv
// Two-port arbiter onto one single-beat Avalon-MM SDRAM master, with an owner-tag FIFO
// routing in-order read responses back and a starvation guard for the low-priority port.
module sdram_arbiter #(
  parameter int unsigned MAX_PENDING  = 8,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [28:0] s0_address_i,
  input  logic        s0_read_i,
  input  logic        s0_write_i,
  input  logic [63:0] s0_writedata_i,
  input  logic [7:0]  s0_byteenable_i,
  output logic        s0_waitrequest_o,
  output logic [63:0] s0_readdata_o,
  output logic        s0_readdatavalid_o,
  input  logic [28:0] s1_address_i,
  input  logic        s1_read_i,
  input  logic        s1_write_i,
  input  logic [63:0] s1_writedata_i,
  input  logic [7:0]  s1_byteenable_i,
  output logic        s1_waitrequest_o,
  output logic [63:0] s1_readdata_o,
  output logic        s1_readdatavalid_o,
  output logic [28:0] m_address_o,
  output logic        m_read_o,
  output logic        m_write_o,
  output logic [63:0] m_writedata_o,
  output logic [7:0]  m_byteenable_o,
  output logic [7:0]  m_burstcount_o,
  input  logic        m_waitrequest_i,
  input  logic [63:0] m_readdata_i,
  input  logic        m_readdatavalid_i,
  output logic        tag_underflow_o,
  output logic [31:0] debug_value_o
);

  localparam int unsigned PtrW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_PENDING) + 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant0 = 2'd1,
    StGrant1 = 2'd2
  } state_e;

  state_e                 state_q;
  logic [CntW-1:0]        pending_q;
  logic [PtrW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [MAX_PENDING-1:0] owner_q;
  logic [7:0]             starve_q;
  logic                   underflow_q;
  logic [28:0]            addr_q;
  logic [63:0]            wdata_q;
  logic [7:0]             be_q;

  logic has_room, elig0, elig1, starved, accept, push, pop, head;

  assign has_room = pending_q < CntW'(MAX_PENDING);
  assign elig0    = s0_write_i | (s0_read_i & has_room);
  assign elig1    = s1_write_i | (s1_read_i & has_room);
  assign starved  = {24'b0, starve_q} >= STARVE_LIMIT;

  // Command bus mirrors the granted port; outside a grant it holds the last values.
  always_comb begin
    m_read_o       = 1'b0;
    m_write_o      = 1'b0;
    m_address_o    = addr_q;
    m_writedata_o  = wdata_q;
    m_byteenable_o = be_q;
    case (state_q)
      StGrant0: begin
        m_write_o      = s0_write_i;
        m_read_o       = s0_read_i & ~s0_write_i;
        m_address_o    = s0_address_i;
        m_writedata_o  = s0_writedata_i;
        m_byteenable_o = s0_byteenable_i;
      end
      StGrant1: begin
        m_write_o      = s1_write_i;
        m_read_o       = s1_read_i & ~s1_write_i;
        m_address_o    = s1_address_i;
        m_writedata_o  = s1_writedata_i;
        m_byteenable_o = s1_byteenable_i;
      end
      default: ;
    endcase
  end

  assign accept           = (m_read_o | m_write_o) & ~m_waitrequest_i;
  assign s0_waitrequest_o = ~((state_q == StGrant0) & accept);
  assign s1_waitrequest_o = ~((state_q == StGrant1) & accept);
  assign push             = accept & m_read_o;
  assign pop              = m_readdatavalid_i & (pending_q != '0);
  assign head             = owner_q[rd_ptr_q];

  assign s0_readdata_o      = m_readdata_i;
  assign s1_readdata_o      = m_readdata_i;
  assign s0_readdatavalid_o = pop & ~head;
  assign s1_readdatavalid_o = pop & head;
  assign m_burstcount_o     = 8'h01;
  assign tag_underflow_o    = underflow_q;
  assign debug_value_o      = {8'(pending_q), starve_q, 6'b0, underflow_q, 1'b0, 4'b0, 2'b0,
                               state_q};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      owner_q     <= '0;
      starve_q    <= 8'd0;
      underflow_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      addr_q  <= m_address_o;
      wdata_q <= m_writedata_o;
      be_q    <= m_byteenable_o;

      case (state_q)
        StIdle: begin
          if (elig0 && elig1) begin
            if (starved) begin
              state_q <= StGrant1;
            end else begin
              state_q <= StGrant0;
              if (starve_q != 8'hFF) starve_q <= starve_q + 8'd1;
            end
          end else if (elig0) begin
            state_q <= StGrant0;
          end else if (elig1) begin
            state_q <= StGrant1;
          end
        end
        StGrant0: begin
          // A dropped request abandons the grant without issuing anything.
          if (!(s0_read_i || s0_write_i) || accept) state_q <= StIdle;
        end
        StGrant1: begin
          if (!(s1_read_i || s1_write_i)) begin
            state_q <= StIdle;
          end else if (accept) begin
            state_q  <= StIdle;
            starve_q <= 8'd0;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (push) begin
        owner_q[wr_ptr_q] <= (state_q == StGrant1);
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      pending_q <= pending_q + 1'b1;
      else if (pop && !push) pending_q <= pending_q - 1'b1;

      if (m_readdatavalid_i && (pending_q == '0)) underflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with MAX_PENDING=2 and STARVE_LIMIT=4.
module tb_sdram_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [28:0] s0_address = '0, s1_address = '0;
  logic        s0_read = 0, s0_write = 0, s1_read = 0, s1_write = 0;
  logic [63:0] s0_writedata = '0, s1_writedata = '0;
  logic [7:0]  s0_byteenable = '0, s1_byteenable = '0;
  logic        s0_waitrequest, s1_waitrequest, s0_rdv, s1_rdv;
  logic [63:0] s0_readdata, s1_readdata;
  logic [28:0] m_address;
  logic        m_read, m_write;
  logic [63:0] m_writedata;
  logic [7:0]  m_byteenable, m_burstcount;
  logic        m_waitrequest = 0;
  logic [63:0] m_readdata = '0;
  logic        m_readdatavalid = 0;
  logic        tag_underflow;
  logic [31:0] dbg;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sdram_arbiter #(.MAX_PENDING(2), .STARVE_LIMIT(4)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .s0_address_i       (s0_address),
    .s0_read_i          (s0_read),
    .s0_write_i         (s0_write),
    .s0_writedata_i     (s0_writedata),
    .s0_byteenable_i    (s0_byteenable),
    .s0_waitrequest_o   (s0_waitrequest),
    .s0_readdata_o      (s0_readdata),
    .s0_readdatavalid_o (s0_rdv),
    .s1_address_i       (s1_address),
    .s1_read_i          (s1_read),
    .s1_write_i         (s1_write),
    .s1_writedata_i     (s1_writedata),
    .s1_byteenable_i    (s1_byteenable),
    .s1_waitrequest_o   (s1_waitrequest),
    .s1_readdata_o      (s1_readdata),
    .s1_readdatavalid_o (s1_rdv),
    .m_address_o        (m_address),
    .m_read_o           (m_read),
    .m_write_o          (m_write),
    .m_writedata_o      (m_writedata),
    .m_byteenable_o     (m_byteenable),
    .m_burstcount_o     (m_burstcount),
    .m_waitrequest_i    (m_waitrequest),
    .m_readdata_i       (m_readdata),
    .m_readdatavalid_i  (m_readdatavalid),
    .tag_underflow_o    (tag_underflow),
    .debug_value_o      (dbg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge after acceptance with the request dropped.
  task automatic issue(input bit p, input bit wr, input logic [28:0] a, input logic [63:0] d);
    int n = 0;
    if (!p) begin
      s0_address = a; s0_writedata = d; s0_byteenable = 8'hFF; s0_read = !wr; s0_write = wr;
    end else begin
      s1_address = a; s1_writedata = d; s1_byteenable = 8'hFF; s1_read = !wr; s1_write = wr;
    end
    #1;
    while (((p == 0) ? s0_waitrequest : s1_waitrequest) !== 1'b0 && n < 50) begin
      @(negedge clock); #1; n++;
    end
    chk("accept_in_time", 64'(n < 50), 64'd1);
    chk("m_address_at_accept", 64'(m_address), 64'(a));
    chk("m_cmd_at_accept", {62'b0, m_write, m_read}, wr ? 64'd2 : 64'd1);
    @(negedge clock);
    s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0;
  endtask

  // Called just after a negedge; drives one response beat for one cycle.
  task automatic resp(input logic [63:0] d, input bit e0, input bit e1);
    m_readdatavalid = 1; m_readdata = d;
    #1;
    chk("s0_rdv", 64'(s0_rdv), 64'(e0));
    chk("s1_rdv", 64'(s1_rdv), 64'(e1));
    chk("readdata", e1 ? s1_readdata : s0_readdata, d);
    @(negedge clock);
    m_readdatavalid = 0;
  endtask

  initial begin
    // Reset state
    @(negedge clock); #1;
    chk("rst_s0_wait", 64'(s0_waitrequest), 64'd1);
    chk("rst_s1_wait", 64'(s1_waitrequest), 64'd1);
    chk("rst_m_cmd", {62'b0, m_write, m_read}, 64'd0);
    chk("rst_rdv", {62'b0, s1_rdv, s0_rdv}, 64'd0);
    chk("rst_m_address", 64'(m_address), 64'd0);
    chk("rst_m_writedata", m_writedata, 64'd0);
    chk("rst_m_be", 64'(m_byteenable), 64'd0);
    chk("burstcount", 64'(m_burstcount), 64'd1);
    chk("rst_debug", 64'(dbg), 64'd0);
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);

    // Port 0 only: four reads, each answered two cycles after acceptance
    for (int i = 0; i < 4; i++) begin
      issue(0, 0, 29'h100 + 29'(i), '0);
      @(negedge clock);
      resp(64'hD0D0_0000_0000_0000 + 64'(i), 1, 0);
    end
    chk("p0_pending_zero", 64'(dbg[31:24]), 64'd0);

    // Interleaved owners: s0 A, s1 B, s0 C
    issue(0, 0, 29'h0A, '0);
    issue(1, 0, 29'h0B, '0);
    chk("il_pending_two", 64'(dbg[31:24]), 64'd2);
    resp(64'hAAAA, 1, 0);
    issue(0, 0, 29'h0C, '0);
    resp(64'hBBBB, 0, 1);
    resp(64'hCCCC, 1, 0);
    chk("il_pending_zero", 64'(dbg[31:24]), 64'd0);

    // Starvation: s0 reads continuously, s1 write waits; 5th decision goes to s1
    s0_address = 29'h200; s0_read = 1;
    s1_address = 29'h300; s1_writedata = 64'hCAFE; s1_byteenable = 8'h0F; s1_write = 1;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin m_readdatavalid = 1; m_readdata = 64'(k); end
      @(negedge clock);
      m_readdatavalid = 0;
      #1;
      chk("sv_state_g0", 64'(dbg[1:0]), 64'd1);
      chk("sv_s0_accept", {62'b0, s1_waitrequest, s0_waitrequest}, 64'd2);
      chk("sv_starve_cnt", 64'(dbg[23:16]), 64'(k));
      @(negedge clock);
    end
    m_readdatavalid = 1; m_readdata = 64'd5;
    @(negedge clock);
    m_readdatavalid = 0;
    #1;
    chk("sv_state_g1", 64'(dbg[1:0]), 64'd2);
    chk("sv_s1_accept", {62'b0, s1_waitrequest, s0_waitrequest}, 64'd1);
    chk("sv_m_cmd", {62'b0, m_write, m_read}, 64'd2);
    chk("sv_m_address", 64'(m_address), 64'h300);
    chk("sv_m_be", 64'(m_byteenable), 64'h0F);
    chk("sv_m_wdata", m_writedata, 64'hCAFE);
    @(negedge clock);
    s0_read = 0; s1_write = 0;
    #1;
    chk("sv_starve_clear", 64'(dbg[23:16]), 64'd0);
    chk("sv_pending_zero", 64'(dbg[31:24]), 64'd0);
    @(negedge clock);

    // Pending limit: two reads outstanding, third held while an s1 write gets through
    issue(0, 0, 29'h10, '0);
    issue(0, 0, 29'h11, '0);
    s0_address = 29'h400; s0_read = 1;
    s1_address = 29'h500; s1_write = 1;
    @(negedge clock); #1;
    chk("pl_state_g1", 64'(dbg[1:0]), 64'd2);
    chk("pl_s1_accept", {62'b0, s1_waitrequest, s0_waitrequest}, 64'd1);
    @(negedge clock);
    s1_write = 0;
    @(negedge clock); #1;
    chk("pl_s0_held_state", 64'(dbg[1:0]), 64'd0);
    chk("pl_s0_held_wait", 64'(s0_waitrequest), 64'd1);
    chk("pl_starve_unchanged", 64'(dbg[23:16]), 64'd0);
    m_readdatavalid = 1; m_readdata = 64'h1010;
    #1;
    chk("pl_resp_rdv", 64'(s0_rdv), 64'd1);
    @(negedge clock);
    m_readdatavalid = 0;
    #1;
    chk("pl_pending_one", 64'(dbg[31:24]), 64'd1);
    @(negedge clock); #1;
    chk("pl_third_state", 64'(dbg[1:0]), 64'd1);
    chk("pl_third_accept", 64'(s0_waitrequest), 64'd0);
    chk("pl_third_addr", 64'(m_address), 64'h400);
    @(negedge clock);
    s0_read = 0;
    #1;
    chk("pl_pending_two", 64'(dbg[31:24]), 64'd2);
    resp(64'h1111, 1, 0);
    resp(64'h4040, 1, 0);
    chk("pl_pending_zero", 64'(dbg[31:24]), 64'd0);

    // m_waitrequest high for 10 cycles in GRANT0
    m_waitrequest = 1; s0_address = 29'h600; s0_read = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #1;
      chk("wr_m_read_high", 64'(m_read), 64'd1);
      chk("wr_s0_wait_high", 64'(s0_waitrequest), 64'd1);
    end
    @(negedge clock);
    m_waitrequest = 0;
    #1;
    chk("wr_accept_low", 64'(s0_waitrequest), 64'd0);
    @(negedge clock);
    s0_read = 0;
    #1;
    chk("wr_pending_one", 64'(dbg[31:24]), 64'd1);
    resp(64'h6060, 1, 0);

    // Stray response with nothing pending
    m_readdatavalid = 1; m_readdata = 64'hDEAD;
    #1;
    chk("uf_no_strobe", {62'b0, s1_rdv, s0_rdv}, 64'd0);
    @(negedge clock);
    m_readdatavalid = 0;
    #1;
    chk("uf_flag_set", 64'(tag_underflow), 64'd1);
    chk("uf_debug_bit", 64'(dbg[9]), 64'd1);
    repeat (3) @(negedge clock);
    #1;
    chk("uf_flag_sticky", 64'(tag_underflow), 64'd1);
    reset_n = 0;
    #1;
    chk("uf_flag_cleared", 64'(tag_underflow), 64'd0);
    chk("uf_rst_debug", 64'(dbg), 64'd0);
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single 64-bit Avalon-MM SDRAM master port between two requesters: port 0 (the frame buffer display reader, high priority) and port 1 (the rasterizer/pixel writer). It sequences one single-beat command at a time onto the SDRAM port and returns in-order read data to the requester that issued it. A starvation guard keeps port 1 from being locked out by continuous display traffic.

## Interface
- MAX_PENDING, 8: maximum outstanding reads (power of 2, 2..16); depth of the owner-tag FIFO.
- STARVE_LIMIT, 16: number of lost arbitrations after which port 1 must win (1..255).
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sN_address  in  29  64-bit-word address (N = 0, 1).
- sN_read / sN_write  in  1  command request, held until accepted.
- sN_writedata  in  64; sN_byteenable  in  8.
- sN_waitrequest  out  1  low for exactly the accepting cycle.
- sN_readdata  out  64  read data, valid with sN_readdatavalid.
- sN_readdatavalid  out  1  one-cycle response strobe.
- m_address  out  29; m_read, m_write  out  1; m_writedata  out  64; m_byteenable  out  8.
- m_burstcount  out  8  constant 8'h01.
- m_waitrequest  in  1; m_readdata  in  64; m_readdatavalid  in  1.
- tag_underflow  out  1  sticky: readdatavalid arrived with no pending read.
- debug_value  out  32  {pending[7:0], starve_cnt[7:0], 6'b0, tag_underflow, 1'b0, 4'b0, 2'b0, state[1:0]}.

## Operation
- States: IDLE (0), GRANT0 (1), GRANT1 (2). Code 3 → IDLE next cycle.
- A port is eligible if sN_write is high, or sN_read is high and pending < MAX_PENDING. sN_read and sN_write both high: write wins for that port.
- IDLE: if neither port is eligible, stay. If only one is eligible, grant it. If both are eligible, grant port 1 when starve_cnt >= STARVE_LIMIT, otherwise grant port 0.
- GRANTn: m_* mirror sN_* combinationally (read is masked off when write is also high). When m_waitrequest is low, the command is accepted: sN_waitrequest is low that cycle, then go to IDLE. If sN drops its request in GRANTn (a protocol violation), go to IDLE with no command issued.
- Outside GRANTn, m_read = m_write = 0. m_address, m_writedata and m_byteenable hold their last values.
- starve_cnt (8-bit, saturating): increments on every IDLE decision where port 1 is eligible and port 0 wins. It clears when GRANT1 accepts a command.
- Tag FIFO: an accepted read pushes its owner bit. On m_readdatavalid the FIFO pops the head, and s<head>_readdatavalid is asserted in the same cycle with sN_readdata = m_readdata. Both sN_readdata outputs always carry m_readdata.
- pending = FIFO occupancy. A push and pop in the same cycle leave it unchanged. It never exceeds MAX_PENDING.
- m_readdatavalid with an empty FIFO: the beat is dropped, no sN_readdatavalid is asserted, and tag_underflow is set until reset.
- Writes are never blocked by pending reads.

## Timing
- Reset values: state IDLE, sN_waitrequest 1, sN_readdatavalid 0, m_read 0, m_write 0, m_address 0, m_writedata 0, m_byteenable 0, pending 0, starve_cnt 0, tag_underflow 0.
- Minimum command cadence is 2 cycles (IDLE decision, then GRANT with m_waitrequest low). With m_waitrequest stuck high, GRANTn holds indefinitely.
- The read response path is combinational: zero added latency.
- Asserting reset mid-operation discards all pending tags. Responses that arrive after reset set tag_underflow.

## Test plan
- Port 0 only: 4 reads to addresses 0x100..0x103, slave returns data D0..D3 two cycles after each accept → s0_readdatavalid ×4 with D0..D3 in order; s1_readdatavalid never asserted; pending returns to 0.
- Interleave: s0 read A, then s1 read B, then s0 read C, responses returned back-to-back → strobes go s0, s1, s0 with the matching data; owner order is preserved.
- Starvation: s0 continuously reading, s1 write pending, STARVE_LIMIT=4 → s1 is accepted on the 5th decision after its request; starve_cnt then reads 0.
- Pending limit: MAX_PENDING=2, slave withholds responses, s0 issues 3 reads → third read is held off; a concurrent s1 write is still accepted; after one response, the third read is accepted.
- m_waitrequest held high for 10 cycles in GRANT0 → m_read stays high, s0_waitrequest stays 1, and the command is accepted on the first low cycle.
- Stray m_readdatavalid with pending=0 → no sN strobe and tag_underflow=1; the flag clears only after reset_n pulses low.
